// File: rtl/udp_tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// udp_tx_sched_pkg
// Shared definitions for the UDP transmit scheduler: FSM state encoding, the
// engine idle encoding, the length/address widths and a length check helper.
// -----------------------------------------------------------------------------
package udp_tx_sched_pkg;

  localparam int LEN_W  = 14;
  localparam int ADDR_W = 13;

  // tx_state value reported by the engine when it is not transmitting
  localparam logic [3:0] TX_IDLE = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // A payload length is legal when it is non-zero and no larger than max_len
  function automatic logic len_legal(input logic [LEN_W-1:0] len,
                                     input logic [LEN_W-1:0] max_len);
    return (len != {LEN_W{1'b0}}) && (len <= max_len);
  endfunction

endpackage

// File: rtl/udp_tx_sched_arb.sv
// -----------------------------------------------------------------------------
// udp_rr_arb2
// Two-requester round-robin arbiter. The grant is a combinational one-hot
// function of the requests and the priority pointer; the pointer only moves
// when advance is high, and then favours the channel that did not win.
//   clk, rst_n : clock, asynchronous active-low reset (channel 0 favoured)
//   req[1:0]   : request levels
//   advance    : the current grant is being consumed
//   grant[1:0] : one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module udp_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Channel that wins when both request
  logic prio_r;
  logic [1:0] grant_s;

  // Grant selection: a lone requester always wins, a tie goes to prio_r
  always_comb begin
    grant_s = 2'b00;
    if (req == 2'b11) begin
      grant_s = prio_r ? 2'b10 : 2'b01;
    end else begin
      grant_s = req;
    end
  end

  // Pointer update: after a consumed grant the other channel gets priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else if (advance && (grant_s != 2'b00)) begin
      prio_r <= grant_s[0];
    end else begin
      prio_r <= prio_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/udp_tx_sched.sv
// -----------------------------------------------------------------------------
// udp_tx_sched
// Shares one UDP/IP transmit engine between two payload sources. Each frame it
// arbitrates round-robin, latches the winner's length, starts the engine,
// watches tx_state for completion (with a timeout) and then holds an
// inter-frame gap before the next grant.
//   e_rxc, reset_n         : byte clock, asynchronous active-low reset
//   req0/1, len0/1         : source requests and payload lengths
//   ack0/1, done0/1        : per-source accept and finish pulses
//   ram0/1_rd_data         : per-source payload RAM read data
//   eng_rd_addr            : engine read address
//   ram_rd_addr/ram_rd_data: steered RAM address / data (combinational)
//   tx_state               : engine transmit state
//   ipsend_en, data_length : engine start and payload length
//   sel, busy              : granted channel, scheduler not idle
//   err_len, err_timeout   : illegal-length reject and timeout pulses
// -----------------------------------------------------------------------------
module udp_tx_sched
  import udp_tx_sched_pkg::*;
#(
  parameter int MAX_LEN    = 1472,
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT    = 65535
) (
  input  logic              e_rxc,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [LEN_W-1:0]  len0,
  output logic              ack0,
  output logic              done0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len1,
  output logic              ack1,
  output logic              done1,
  input  logic [31:0]       ram0_rd_data,
  input  logic [31:0]       ram1_rd_data,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [31:0]       ram_rd_data,
  input  logic [3:0]        tx_state,
  output logic              ipsend_en,
  output logic [LEN_W-1:0]  data_length,
  output logic              sel,
  output logic              busy,
  output logic              err_len,
  output logic              err_timeout
);

  // One counter serves the ARM/SEND timeout and the GAP length
  localparam int CNT_MAX = (TIMEOUT > IFG_CYCLES) ? TIMEOUT : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_END_C = CNT_W'(IFG_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ack0_r, ack1_r, done0_r, done1_r;
  logic               ipsend_en_r, sel_r, busy_r, err_len_r, err_timeout_r;
  logic [LEN_W-1:0]   data_length_r;
  logic [1:0]         grant_s;
  logic               advance_s;
  logic               winner_s;
  logic [LEN_W-1:0]   win_len_s;

  // A grant is consumed (legal or not) whenever it is seen in IDLE
  assign advance_s = (state_r == ST_IDLE);
  assign winner_s  = grant_s[1];
  assign win_len_s = winner_s ? len1 : len0;

  udp_rr_arb2 u_arb (
    .clk     (e_rxc),
    .rst_n   (reset_n),
    .req     ({req1, req0}),
    .advance (advance_s),
    .grant   (grant_s)
  );

  // Scheduler FSM with all engine/source-facing outputs registered
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      ack0_r        <= 1'b0;
      ack1_r        <= 1'b0;
      done0_r       <= 1'b0;
      done1_r       <= 1'b0;
      ipsend_en_r   <= 1'b0;
      sel_r         <= 1'b0;
      busy_r        <= 1'b0;
      err_len_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      data_length_r <= {LEN_W{1'b0}};
    end else begin
      // pulse outputs default low every cycle
      ack0_r        <= 1'b0;
      ack1_r        <= 1'b0;
      done0_r       <= 1'b0;
      done1_r       <= 1'b0;
      err_len_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ipsend_en_r <= 1'b0;
          cnt_r       <= {CNT_W{1'b0}};
          if (grant_s != 2'b00) begin
            ack0_r <= grant_s[0];
            ack1_r <= grant_s[1];
            sel_r  <= winner_s;
            if (len_legal(win_len_s, MAX_LEN_C)) begin
              data_length_r <= win_len_s;
              state_r       <= ST_ARM;
              busy_r        <= 1'b1;
            end else begin
              // rejected: accept and finish in the same cycle
              done0_r   <= grant_s[0];
              done1_r   <= grant_s[1];
              err_len_r <= 1'b1;
              busy_r    <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ARM: begin
          if (tx_state != TX_IDLE) begin
            ipsend_en_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            state_r     <= ST_SEND;
          end else if (cnt_r == TIMEOUT_C) begin
            ipsend_en_r   <= 1'b0;
            err_timeout_r <= 1'b1;
            done0_r       <= ~sel_r;
            done1_r       <= sel_r;
            cnt_r         <= {CNT_W{1'b0}};
            state_r       <= ST_GAP;
          end else begin
            ipsend_en_r <= 1'b1;
            cnt_r       <= cnt_r + CNT_W'(1);
          end
        end
        ST_SEND: begin
          ipsend_en_r <= 1'b0;
          if (tx_state == TX_IDLE) begin
            done0_r <= ~sel_r;
            done1_r <= sel_r;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_GAP;
          end else if (cnt_r == TIMEOUT_C) begin
            err_timeout_r <= 1'b1;
            done0_r       <= ~sel_r;
            done1_r       <= sel_r;
            cnt_r         <= {CNT_W{1'b0}};
            state_r       <= ST_GAP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_GAP: begin
          ipsend_en_r <= 1'b0;
          if (cnt_r == GAP_END_C) begin
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          ipsend_en_r <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= {CNT_W{1'b0}};
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // sel only moves on a grant, so the steering is stable for the whole frame
  assign ram_rd_addr = eng_rd_addr;
  assign ram_rd_data = sel_r ? ram1_rd_data : ram0_rd_data;

  assign ack0        = ack0_r;
  assign ack1        = ack1_r;
  assign done0       = done0_r;
  assign done1       = done1_r;
  assign ipsend_en   = ipsend_en_r;
  assign data_length = data_length_r;
  assign sel         = sel_r;
  assign busy        = busy_r;
  assign err_len     = err_len_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_udp_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_sched
// Directed bench for udp_tx_sched (TIMEOUT overridden to 20, IFG_CYCLES 12).
// Inputs are driven and registered outputs sampled 1 time unit after the
// rising edge of e_rxc.
// -----------------------------------------------------------------------------
module tb_udp_tx_sched;

  localparam int IFG = 12;

  logic        e_rxc   = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [13:0] len0 = 14'd0, len1 = 14'd0;
  logic        ack0, ack1, done0, done1;
  logic [31:0] ram0_rd_data = 32'd0, ram1_rd_data = 32'd0;
  logic [12:0] eng_rd_addr = 13'd0;
  logic [12:0] ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [3:0]  tx_state = 4'd0;
  logic        ipsend_en;
  logic [13:0] data_length;
  logic        sel, busy, err_len, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  udp_tx_sched #(.TIMEOUT(20)) dut (
    .e_rxc        (e_rxc),
    .reset_n      (reset_n),
    .req0         (req0),
    .len0         (len0),
    .ack0         (ack0),
    .done0        (done0),
    .req1         (req1),
    .len1         (len1),
    .ack1         (ack1),
    .done1        (done1),
    .ram0_rd_data (ram0_rd_data),
    .ram1_rd_data (ram1_rd_data),
    .eng_rd_addr  (eng_rd_addr),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .tx_state     (tx_state),
    .ipsend_en    (ipsend_en),
    .data_length  (data_length),
    .sel          (sel),
    .busy         (busy),
    .err_len      (err_len),
    .err_timeout  (err_timeout)
  );

  // Free-running byte clock
  always #5 e_rxc = ~e_rxc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge e_rxc);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge e_rxc);
    #1;
    reset_n = 1'b1;
  endtask

  // Wait (bounded) for an ack; ch = -1 when none arrives
  task automatic wait_ack(input int max_cyc, output int ch);
    ch = -1;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (ack0) begin ch = 0; break; end
      if (ack1) begin ch = 1; break; end
    end
  endtask

  // From the cycle after ack: engine starts, finishes, then the gap runs out
  task automatic complete_frame();
    tx_state = 4'd1;
    tick();
    tx_state = 4'd0;
    tick();
    repeat (IFG) tick();
  endtask

  initial begin
    int got;
    int ch;
    int hi;
    int seen;

    ram0_rd_data = 32'hA0A0_1234;
    ram1_rd_data = 32'hB1B1_5678;
    eng_rd_addr  = 13'h0ABC;
    apply_reset();

    // ---------------- reset state ----------------
    check_val("rst_ipsend", 32'(ipsend_en), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_sel", 32'(sel), 32'd0);
    check_val("rst_len", 32'(data_length), 32'd0);
    check_val("rst_ack0", 32'(ack0), 32'd0);
    check_val("rst_err_len", 32'(err_len), 32'd0);
    check_val("addr_pass", 32'(ram_rd_addr), 32'h0ABC);
    check_val("rst_rd_data", ram_rd_data, 32'hA0A0_1234);

    // ---------------- single request, len 100 ----------------
    req0 = 1'b1; len0 = 14'd100;
    tick();
    check_val("t1_ack0", 32'(ack0), 32'd1);
    check_val("t1_len", 32'(data_length), 32'd100);
    check_val("t1_ipsend_lat", 32'(ipsend_en), 32'd0);
    check_val("t1_busy", 32'(busy), 32'd1);
    req0 = 1'b0;
    tick();
    check_val("t1_ack_once", 32'(ack0), 32'd0);
    check_val("t1_ipsend_up", 32'(ipsend_en), 32'd1);
    tx_state = 4'd1;
    tick();
    check_val("t1_ipsend_dn", 32'(ipsend_en), 32'd0);
    repeat (3) tick();
    check_val("t1_no_done", 32'(done0), 32'd0);
    tx_state = 4'd0;
    tick();
    check_val("t1_done0", 32'(done0), 32'd1);
    req0 = 1'b1;
    got = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) check_val("t1_done_once", 32'(done0), 32'd0);
      if (ack0) begin got = i; break; end
    end
    check_val("t1_ifg_ack", 32'(got), 32'd13);
    req0 = 1'b0;
    complete_frame();

    // ---------------- both requesting, alternate ----------------
    apply_reset();
    req0 = 1'b1; len0 = 14'd64;
    req1 = 1'b1; len1 = 14'd200;
    for (int k = 0; k < 4; k++) begin
      ram0_rd_data = 32'h1000_0000 + 32'(k);
      ram1_rd_data = 32'h2000_0000 + 32'(k);
      wait_ack(40, ch);
      check_val($sformatf("t2_grant%0d", k), 32'(ch), 32'(k % 2));
      check_val($sformatf("t2_sel%0d", k), 32'(sel), 32'(k % 2));
      check_val($sformatf("t2_len%0d", k), 32'(data_length), (k % 2 == 0) ? 32'd64 : 32'd200);
      check_val($sformatf("t2_rdata%0d", k), ram_rd_data,
                (k % 2 == 0) ? (32'h1000_0000 + 32'(k)) : (32'h2000_0000 + 32'(k)));
      complete_frame();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // ---------------- illegal lengths on channel 1 ----------------
    req1 = 1'b1; len1 = 14'd0;
    tick();
    check_val("t3_z_ack1", 32'(ack1), 32'd1);
    check_val("t3_z_done1", 32'(done1), 32'd1);
    check_val("t3_z_err", 32'(err_len), 32'd1);
    check_val("t3_z_busy", 32'(busy), 32'd0);
    check_val("t3_z_ipsend", 32'(ipsend_en), 32'd0);
    check_val("t3_z_len_hold", 32'(data_length), 32'd200);
    len1 = 14'd1500;
    tick();
    check_val("t3_big_ack1", 32'(ack1), 32'd1);
    check_val("t3_big_done1", 32'(done1), 32'd1);
    check_val("t3_big_err", 32'(err_len), 32'd1);
    check_val("t3_big_busy", 32'(busy), 32'd0);
    check_val("t3_big_ipsend", 32'(ipsend_en), 32'd0);
    len1 = 14'd1472;
    tick();
    check_val("t3_max_ack1", 32'(ack1), 32'd1);
    check_val("t3_max_err", 32'(err_len), 32'd0);
    check_val("t3_max_done1", 32'(done1), 32'd0);
    check_val("t3_max_len", 32'(data_length), 32'd1472);
    req1 = 1'b0;
    complete_frame();

    // ---------------- timeout: engine never starts ----------------
    req0 = 1'b1; len0 = 14'd10;
    tick();
    check_val("t4_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    hi = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (err_timeout) begin
        seen = 1;
        check_val("t4_done0", 32'(done0), 32'd1);
        break;
      end
      if (ipsend_en) hi++;
    end
    check_val("t4_seen", 32'(seen), 32'd1);
    check_val("t4_ipsend_cycles", 32'(hi), 32'd20);
    repeat (IFG - 1) tick();
    check_val("t4_gap_busy", 32'(busy), 32'd1);
    tick();
    check_val("t4_idle", 32'(busy), 32'd0);

    // ---------------- reset mid-frame ----------------
    req1 = 1'b1; len1 = 14'd300;
    tick();
    check_val("t5_ack1", 32'(ack1), 32'd1);
    check_val("t5_sel1", 32'(sel), 32'd1);
    req1 = 1'b0;
    tx_state = 4'd1;
    tick();
    tick();
    check_val("t5_send_busy", 32'(busy), 32'd1);
    req0 = 1'b1; req1 = 1'b1; len0 = 14'd50;
    #2;
    reset_n = 1'b0;
    #1;
    check_val("t5_rst_ipsend", 32'(ipsend_en), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_sel", 32'(sel), 32'd0);
    check_val("t5_rst_len", 32'(data_length), 32'd0);
    #1;
    reset_n  = 1'b1;
    tx_state = 4'd0;
    tick();
    check_val("t5_first_ack0", 32'(ack0), 32'd1);
    check_val("t5_first_ack1", 32'(ack1), 32'd0);
    check_val("t5_first_sel", 32'(sel), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
